// File: rtl/ds1302_pkg.sv
// Shared definitions for the DS1302 access scheduler: FSM state encoding,
// packed-time field offsets and the clock-halt bit position.
package ds1302_pkg;

    // FSM state encoding (3 bits)
    localparam int STATE_W = 3;
    localparam logic [STATE_W-1:0] ST_BOOT   = 3'd0;
    localparam logic [STATE_W-1:0] ST_CHK_RD = 3'd1;
    localparam logic [STATE_W-1:0] ST_CHK_WR = 3'd2;
    localparam logic [STATE_W-1:0] ST_IDLE   = 3'd3;
    localparam logic [STATE_W-1:0] ST_RD     = 3'd4;
    localparam logic [STATE_W-1:0] ST_WR     = 3'd5;

    typedef enum logic [STATE_W-1:0] {
        S_BOOT   = ST_BOOT,
        S_CHK_RD = ST_CHK_RD,
        S_CHK_WR = ST_CHK_WR,
        S_IDLE   = ST_IDLE,
        S_RD     = ST_RD,
        S_WR     = ST_WR
    } state_t;

    // Packed time word: {year,week,month,date,hour,minute,second}, one BCD byte each
    localparam int TIME_W    = 56;
    localparam int SEC_LSB   = 0;
    localparam int MIN_LSB   = 8;
    localparam int HOUR_LSB  = 16;
    localparam int DATE_LSB  = 24;
    localparam int MONTH_LSB = 32;
    localparam int WEEK_LSB  = 40;
    localparam int YEAR_LSB  = 48;

    // Clock-halt flag lives in the top bit of the seconds register
    localparam int CH_BIT = SEC_LSB + 7;

    // True while the start-up clock-halt check/repair is still running
    function automatic logic is_boot_phase(input state_t s);
        return (s == S_BOOT) || (s == S_CHK_RD) || (s == S_CHK_WR);
    endfunction

endpackage

// File: rtl/ds1302_access_sched_if.sv
// Bundle of the user-side and driver-side signals of the DS1302 access
// scheduler. The master modport is the scheduler itself (it issues the
// driver requests and publishes time); the slave modport is its
// environment (user logic plus the ds1302 serial driver).
interface ds1302_access_sched_if;
    import ds1302_pkg::*;

    // User set-time port
    logic              set_req;
    logic [TIME_W-1:0] set_time;
    logic              set_ready;
    logic              set_done;

    // Published time snapshot
    logic [TIME_W-1:0] time_bcd;
    logic              time_valid;

    // ds1302 driver handshake
    logic              drv_read_req;
    logic              drv_read_ack;
    logic              drv_write_req;
    logic              drv_write_ack;
    logic [TIME_W-1:0] drv_wdata;
    logic [TIME_W-1:0] drv_rdata;

    // Status / debug
    logic              err;
    state_t            state_dbg;

    modport master (
        input  set_req, set_time, drv_read_ack, drv_write_ack, drv_rdata,
        output set_ready, set_done, time_bcd, time_valid,
               drv_read_req, drv_write_req, drv_wdata, err, state_dbg
    );

    modport slave (
        output set_req, set_time, drv_read_ack, drv_write_ack, drv_rdata,
        input  set_ready, set_done, time_bcd, time_valid,
               drv_read_req, drv_write_req, drv_wdata, err, state_dbg
    );

endinterface

// File: rtl/ds1302_period_timer.sv
// Free-running cycle counter with synchronous clear and a one-cycle wrap
// pulse on the PERIOD-th enabled cycle. Used for the periodic-read interval
// and, when enabled, for the driver ack timeout.
module ds1302_period_timer #(
    parameter int unsigned PERIOD = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic wrap
);

    localparam int unsigned CW = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    localparam logic [CW-1:0] LAST = CW'(PERIOD - 1);

    logic [CW-1:0] cnt;

    // Wrap is reported on the cycle the counter sits at its last value while enabled
    assign wrap = en && !clr && (cnt == LAST);

    // Count enabled cycles, returning to zero after LAST; clear has priority
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= (cnt == LAST) ? '0 : cnt + CW'(1);
        end
    end

endmodule

// File: rtl/ds1302_access_sched.sv
// DS1302 access scheduler: owns the ds1302 driver read/write handshakes,
// performs the power-up clock-halt check and repair, issues periodic time
// reads, arbitrates user set-time requests against them and publishes a
// captured BCD time snapshot.
// Optional build macro: DS1302_SCHED_TIMEOUT_EN adds a driver ack timeout
// with a sticky err flag; without it err is tied low and acks are awaited
// indefinitely.
//
// Handshakes:
//   driver : a req rises on the edge the FSM enters a read/write state and
//            stays high until the one-cycle ack is sampled; on that edge the
//            req drops and the FSM leaves. drv_wdata is loaded on entry and
//            held until the ack. Read and write req are never high together.
//   user   : set_req is accepted on any edge where set_req && set_ready;
//            set_time is captured then, and set_done pulses for one cycle
//            once the matching driver write is acked.
module ds1302_access_sched
    import ds1302_pkg::*;
#(
    parameter int unsigned       READ_PERIOD = 50_000_000,
    parameter logic [TIME_W-1:0] DEF_TIME    = 56'h20_03_11_11_18_11_00,
    parameter int unsigned       TIMEOUT     = 1_000_000
) (
    input  logic                  clk,
    input  logic                  rst,
    ds1302_access_sched_if.master bus
);

    state_t            state;
    state_t            state_n;
    logic              pend;
    logic              pend_n;
    logic [TIME_W-1:0] pend_data;
    logic [TIME_W-1:0] pend_sel;
    logic              set_ready;
    logic              set_acc;
    logic              rd_ack;
    logic              wr_ack;
    logic              period_wrap;
    logic              timeout_hit;
    logic              tv_n;
    logic              done_n;
    logic              read_req;
    logic              write_req;
    logic [TIME_W-1:0] wdata_q;
    logic [TIME_W-1:0] time_q;
    logic              time_valid_q;
    logic              set_done_q;

    // Out-of-range parameters leave this marker block in the elaborated hierarchy
    if (READ_PERIOD < 16 || TIMEOUT < 2) begin : g_param_out_of_range
    end

    // Requests are a pure function of the registered state, so they rise on
    // state entry and drop on the edge that leaves the state.
    assign read_req  = (state == S_CHK_RD) || (state == S_RD);
    assign write_req = (state == S_CHK_WR) || (state == S_WR);

    // Acks only count while the matching request is outstanding
    assign rd_ack = bus.drv_read_ack  && read_req;
    assign wr_ack = bus.drv_write_ack && write_req;

    // One set-time request may be buffered, and none during the boot check
    assign set_ready = !pend && !is_boot_phase(state);
    assign set_acc   = bus.set_req && set_ready;

    // A request accepted this very cycle is already the one to write
    assign pend_sel = set_acc ? bus.set_time : pend_data;

    ds1302_period_timer #(
        .PERIOD (READ_PERIOD)
    ) u_period (
        .clk  (clk),
        .rst  (rst),
        .clr  (rd_ack && (state == S_RD)),
        .en   (state == S_IDLE),
        .wrap (period_wrap)
    );

`ifdef DS1302_SCHED_TIMEOUT_EN
    logic req_active;
    logic err_q;

    assign req_active = read_req || write_req;

    ds1302_period_timer #(
        .PERIOD (TIMEOUT)
    ) u_timeout (
        .clk  (clk),
        .rst  (rst),
        .clr  (!req_active || rd_ack || wr_ack),
        .en   (req_active),
        .wrap (timeout_hit)
    );

    // Sticky timeout flag, cleared only by reset
    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if (timeout_hit) begin
            err_q <= 1'b1;
        end
    end

    assign bus.err = err_q;
`else
    assign timeout_hit = 1'b0;
    assign bus.err     = 1'b0;
`endif

    // Next-state, pending-write and pulse decode
    always_comb begin
        state_n = state;
        pend_n  = pend;
        tv_n    = 1'b0;
        done_n  = 1'b0;
        if (set_acc) begin
            pend_n = 1'b1;
        end
        case (state)
            S_BOOT: begin
                state_n = S_CHK_RD;
            end
            S_CHK_RD: begin
                if (rd_ack) begin
                    if (bus.drv_rdata[CH_BIT]) begin
                        state_n = S_CHK_WR;
                    end else begin
                        state_n = S_IDLE;
                        tv_n    = 1'b1;
                    end
                end
            end
            S_CHK_WR: begin
                // After repairing CH, re-read so the snapshot reflects the chip
                if (wr_ack) begin
                    state_n = S_RD;
                end
            end
            S_IDLE: begin
                // A waiting write beats a read that falls due on the same cycle
                if (pend || set_acc) begin
                    state_n = S_WR;
                end else if (period_wrap) begin
                    state_n = S_RD;
                end
            end
            S_RD: begin
                if (rd_ack) begin
                    state_n = S_IDLE;
                    tv_n    = 1'b1;
                end
            end
            S_WR: begin
                if (wr_ack) begin
                    state_n = S_RD;
                    done_n  = 1'b1;
                    pend_n  = 1'b0;
                end
            end
            default: begin
                state_n = S_BOOT;
            end
        endcase
        // An abandoned transaction also abandons any buffered user write
        if (timeout_hit) begin
            state_n = S_IDLE;
            pend_n  = 1'b0;
            tv_n    = 1'b0;
            done_n  = 1'b0;
        end
    end

    // State register and the single-entry set-time buffer
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_BOOT;
            pend      <= 1'b0;
            pend_data <= '0;
        end else begin
            state <= state_n;
            pend  <= pend_n;
            if (set_acc) begin
                pend_data <= bus.set_time;
            end
        end
    end

    // Registered outputs: write data loaded on entry to a write state,
    // snapshot and pulses updated on the acking edge
    always_ff @(posedge clk) begin
        if (rst) begin
            wdata_q      <= '0;
            time_q       <= '0;
            time_valid_q <= 1'b0;
            set_done_q   <= 1'b0;
        end else begin
            time_valid_q <= tv_n;
            set_done_q   <= done_n;
            if (tv_n) begin
                time_q <= bus.drv_rdata;
            end
            if (state_n == S_CHK_WR && state != S_CHK_WR) begin
                wdata_q <= DEF_TIME;
            end else if (state_n == S_WR && state != S_WR) begin
                wdata_q <= pend_sel;
            end
        end
    end

    assign bus.drv_read_req  = read_req;
    assign bus.drv_write_req = write_req;
    assign bus.drv_wdata     = wdata_q;
    assign bus.time_bcd      = time_q;
    assign bus.time_valid    = time_valid_q;
    assign bus.set_done      = set_done_q;
    assign bus.set_ready     = set_ready;
    assign bus.state_dbg     = state;

endmodule

// File: tb/tb_ds1302_access_sched.sv
// Bench for ds1302_access_sched: a ds1302 driver model with a small RTC
// register, directed stimulus with hand-computed expectations, and a
// negedge monitor that pops expected write data / set_done values from
// queues and checks every published time snapshot.
module tb_ds1302_access_sched;
    import ds1302_pkg::*;

    localparam int unsigned RP      = 100;
    localparam int unsigned TO      = 50;
    localparam int          ACK_LAT = 3;
    // Read req rise-to-rise spacing: RP idle cycles plus ACK_LAT+1 read cycles
    localparam int          RD_GAP  = 104;
    localparam logic [55:0] DEF     = 56'h20_03_11_11_18_11_00;

    localparam logic [55:0] T1  = 56'h24_02_06_15_09_45_30;
    localparam logic [55:0] T2  = 56'h24_01_01_01_00_00_80;
    localparam logic [55:0] S4  = 56'h21_01_02_03_04_05_06;
    localparam logic [55:0] S5  = 56'h22_07_12_31_23_59_58;
    localparam logic [55:0] S5B = 56'h23_03_04_05_06_07_08;
    localparam logic [55:0] S6  = 56'h19_05_09_10_11_12_13;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    ds1302_access_sched_if bus ();

    ds1302_access_sched #(
        .READ_PERIOD (RP),
        .TIMEOUT     (TO)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // ---------------- bookkeeping ----------------
    int          errors = 0;
    int          checks = 0;
    int          wr_rises = 0;
    int          done_seen = 0;
    logic [55:0] exp_wdata_q[$];
    logic [55:0] exp_done_q[$];
    logic [55:0] exp_time_now = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic note_fail(input string name, input string detail);
        checks++;
        errors++;
        $display("FAIL %s: %s (cycle %0d)", name, detail, cyc);
    endtask

    // ---------------- driver model ----------------
    logic        hold_ack = 1'b0;
    logic [55:0] rtc_time = '0;
    int          lat = 0;

    initial begin
        bus.drv_read_ack  = 1'b0;
        bus.drv_write_ack = 1'b0;
        bus.drv_rdata     = '0;
        forever begin
            @(posedge clk);
            #1;
            bus.drv_read_ack  = 1'b0;
            bus.drv_write_ack = 1'b0;
            if (bus.drv_read_req || bus.drv_write_req) begin
                if (lat >= ACK_LAT && !hold_ack) begin
                    if (bus.drv_read_req) begin
                        bus.drv_rdata    = rtc_time;
                        bus.drv_read_ack = 1'b1;
                    end else begin
                        rtc_time          = bus.drv_wdata;
                        bus.drv_write_ack = 1'b1;
                    end
                    lat = 0;
                end else begin
                    lat++;
                end
            end else begin
                lat = 0;
            end
        end
    end

    // ---------------- monitor / scoreboard ----------------
    logic        prev_wr = 1'b0;
    logic [55:0] held_wdata = '0;
    logic [55:0] prev_time = '0;
    logic [55:0] done_exp;

    always @(negedge clk) begin
        if (rst) begin
            prev_wr   = 1'b0;
            prev_time = bus.time_bcd;
        end else begin
            check("req_exclusive", 64'(bus.drv_read_req & bus.drv_write_req), 64'd0);
            if (bus.drv_write_req && !prev_wr) begin
                wr_rises++;
                if (exp_wdata_q.size() == 0) begin
                    note_fail("write_data", $sformatf("unexpected write of %0h", bus.drv_wdata));
                end else begin
                    check("write_data", bus.drv_wdata, exp_wdata_q.pop_front());
                end
                held_wdata = bus.drv_wdata;
            end else if (bus.drv_write_req && (bus.drv_wdata !== held_wdata)) begin
                check("wdata_stable", bus.drv_wdata, held_wdata);
            end
            prev_wr = bus.drv_write_req;

            if (bus.set_done) begin
                done_seen++;
                if (exp_done_q.size() == 0) begin
                    note_fail("set_done", "unexpected set_done pulse");
                end else begin
                    done_exp = exp_done_q.pop_front();
                    check("set_done_data", held_wdata, done_exp);
                    exp_time_now = done_exp;
                end
            end

            if (bus.time_valid) begin
                check("time_bcd", bus.time_bcd, exp_time_now);
            end else if (bus.time_bcd !== prev_time) begin
                check("time_bcd_hold", bus.time_bcd, prev_time);
            end
            prev_time = bus.time_bcd;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic apply_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_state"}, 64'(bus.state_dbg), 64'(S_BOOT));
        check({tag, "_read_req"}, 64'(bus.drv_read_req), 64'd0);
        check({tag, "_write_req"}, 64'(bus.drv_write_req), 64'd0);
        check({tag, "_wdata"}, 64'(bus.drv_wdata), 64'd0);
        check({tag, "_time_bcd"}, 64'(bus.time_bcd), 64'd0);
        check({tag, "_time_valid"}, 64'(bus.time_valid), 64'd0);
        check({tag, "_set_done"}, 64'(bus.set_done), 64'd0);
        check({tag, "_err"}, 64'(bus.err), 64'd0);
        check({tag, "_set_ready"}, 64'(bus.set_ready), 64'd0);
    endtask

    task automatic wait_tv(input string name, input int budget);
        for (int i = 0; i < budget; i++) begin
            @(posedge clk);
            #1;
            if (bus.time_valid) return;
        end
        note_fail(name, "no time_valid within cycle budget");
    endtask

    task automatic wait_rd_rise(input string name, input int budget, output int at);
        logic prev;
        prev = bus.drv_read_req;
        at   = -1;
        for (int i = 0; i < budget; i++) begin
            @(posedge clk);
            #1;
            if (bus.drv_read_req && !prev) begin
                at = cyc;
                return;
            end
            prev = bus.drv_read_req;
        end
        note_fail(name, "no drv_read_req rise within cycle budget");
    endtask

    // ---------------- stimulus ----------------
    int rise_a;
    int rise_b;

    initial begin
        bus.set_req  = 1'b0;
        bus.set_time = '0;

        // 1: boot with CH=0 -> no write, snapshot equals chip time
        rtc_time     = T1;
        exp_time_now = T1;
        apply_reset();
        check_reset_values("reset1");
        wait_tv("boot_ch0", 50);
        check("boot_ch0_writes", 64'(wr_rises), 64'd0);
        check("boot_ch0_state", 64'(bus.state_dbg), 64'(S_IDLE));
        check("boot_ch0_set_ready", 64'(bus.set_ready), 64'd1);

        // 2: boot with CH=1 -> DEF_TIME written, re-read; set_req during boot ignored
        rtc_time     = T2;
        exp_time_now = DEF;
        exp_wdata_q.push_back(DEF);
        apply_reset();
        check_reset_values("reset2");
        bus.set_req  = 1'b1;
        bus.set_time = S5B;
        @(posedge clk);
        #1;
        bus.set_req = 1'b0;
        check("boot_chk_set_ready", 64'(bus.set_ready), 64'd0);
        wait_tv("boot_ch1", 100);
        check("boot_ch1_writes", 64'(wr_rises), 64'd1);
        check("boot_ch1_done", 64'(done_seen), 64'd0);

        // 3: periodic read spacing
        wait_rd_rise("period_a", 200, rise_a);
        wait_rd_rise("period_b", 200, rise_b);
        check("period_gap", 64'(rise_b - rise_a), 64'(RD_GAP));

        // 4: set_req on the counter-wrap cycle -> write first, then read
        wait_tv("collide_pre", 20);
        repeat (RP - 1) @(posedge clk);
        #1;
        check("collide_state", 64'(bus.state_dbg), 64'(S_IDLE));
        check("collide_set_ready", 64'(bus.set_ready), 64'd1);
        bus.set_req  = 1'b1;
        bus.set_time = S4;
        exp_wdata_q.push_back(S4);
        exp_done_q.push_back(S4);
        @(posedge clk);
        #1;
        bus.set_req = 1'b0;
        check("collide_write_req", 64'(bus.drv_write_req), 64'd1);
        check("collide_read_req", 64'(bus.drv_read_req), 64'd0);
        check("collide_set_ready_busy", 64'(bus.set_ready), 64'd0);
        wait_tv("collide_post", 50);
        check("collide_done", 64'(done_seen), 64'd1);
        check("collide_writes", 64'(wr_rises), 64'd2);

        // 5: set_req during a read is latched; a second one is ignored
        wait_rd_rise("rd_set", 200, rise_a);
        check("rd_set_state", 64'(bus.state_dbg), 64'(S_RD));
        check("rd_set_ready", 64'(bus.set_ready), 64'd1);
        bus.set_req  = 1'b1;
        bus.set_time = S5;
        exp_wdata_q.push_back(S5);
        exp_done_q.push_back(S5);
        @(posedge clk);
        #1;
        check("rd_set_ready_busy", 64'(bus.set_ready), 64'd0);
        bus.set_time = S5B;
        @(posedge clk);
        #1;
        bus.set_req = 1'b0;
        wait_tv("rd_set_first", 20);
        wait_tv("rd_set_second", 50);
        check("rd_set_done", 64'(done_seen), 64'd2);
        check("rd_set_writes", 64'(wr_rises), 64'd3);

        // 6: reset while a write is outstanding drops the req and discards it
        hold_ack     = 1'b1;
        bus.set_req  = 1'b1;
        bus.set_time = S6;
        exp_wdata_q.push_back(S6);
        @(posedge clk);
        #1;
        bus.set_req = 1'b0;
        check("midrst_write_req", 64'(bus.drv_write_req), 64'd1);
        repeat (3) @(posedge clk);
        #1;
        check("midrst_write_held", 64'(bus.drv_write_req), 64'd1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("midrst_write_drop", 64'(bus.drv_write_req), 64'd0);
        check("midrst_read_drop", 64'(bus.drv_read_req), 64'd0);
        check("midrst_state", 64'(bus.state_dbg), 64'(S_BOOT));
        hold_ack = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        wait_tv("midrst_boot", 50);
        check("midrst_done", 64'(done_seen), 64'd2);
        check("midrst_writes", 64'(wr_rises), 64'd4);
        check("midrst_set_ready", 64'(bus.set_ready), 64'd1);

`ifdef DS1302_SCHED_TIMEOUT_EN
        // 7: withheld ack -> req drops after TO cycles, sticky err until reset
        hold_ack = 1'b1;
        wait_rd_rise("to_rise", 200, rise_a);
        repeat (TO - 1) @(posedge clk);
        #1;
        check("to_req_before", 64'(bus.drv_read_req), 64'd1);
        check("to_err_before", 64'(bus.err), 64'd0);
        @(posedge clk);
        #1;
        check("to_req_after", 64'(bus.drv_read_req), 64'd0);
        check("to_err_after", 64'(bus.err), 64'd1);
        check("to_state", 64'(bus.state_dbg), 64'(S_IDLE));
        hold_ack = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        check("to_err_sticky", 64'(bus.err), 64'd1);
        apply_reset();
        check("to_err_reset", 64'(bus.err), 64'd0);
        wait_tv("to_reboot", 50);
`endif

        // final scoreboard state
        repeat (5) @(posedge clk);
        #1;
        check("wdata_queue_empty", 64'(exp_wdata_q.size()), 64'd0);
        check("done_queue_empty", 64'(exp_done_q.size()), 64'd0);
        check("total_set_done", 64'(done_seen), 64'd2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Hard stop in case a wait outside the bounded tasks stalls
    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit (errors=%0d)", errors);
        $fatal(1, "watchdog");
    end

endmodule
